// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multicycle control unit for the 16-bit NITC-RISC24 core.
//               Drives the datapath select/enable lines. It also handles a
//               memory req/ack handshake with wait states and a bus timeout
//               that leads to a sticky FAULT state. It keeps carry/zero flags,
//               supports cz-conditional execution and detects illegal
//               instructions.
// Optional    : MC_CTRL_PERF_EN builds the retired-instruction counter.
//               Without it, instr_count is tied to 0.
// Ports       : clk, reset (async, active-high)
//               op[3:0], cz[1:0]      - instruction fields from IR
//               alu_zero, alu_carry   - combinational ALU status
//               mem_ack               - memory completes access this cycle
//               mem_req, mem_we, iord - memory interface controls
//               ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
//               reg_write, reg_dst, mem_to_reg - datapath controls
//               flag_c, flag_z        - architectural flags
//               illegal_op            - pulse on undecodable instruction
//               fault                 - sticky bus-timeout flag
//               instr_count[CNT_W-1:0]- retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [1:0]       cz,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             flag_c,
    output logic             flag_z,
    output logic             illegal_op,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    localparam logic [3:0]      C_OP_ADD  = 4'b0000;
    localparam logic [3:0]      C_OP_NAND = 4'b0010;
    localparam logic [3:0]      C_OP_SW   = 4'b1001;
    localparam logic [3:0]      C_OP_LW   = 4'b1010;
    localparam logic [3:0]      C_OP_BEQ  = 4'b1011;
    localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] C_ONE     = TO_W'(1);

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_wait;
    logic            r_flag_c;
    logic            r_flag_z;
    logic            w_alu_group;
    logic            w_cond_ok;
    logic            w_suppress;
    logic            w_wait_state;
    logic            w_timeout;

    assign w_alu_group = (op == C_OP_ADD) || (op == C_OP_NAND);

    // cz selects the execution condition: 00 always, 10 on C, 01 on Z.
    // cz=11 is rejected separately as illegal.
    always_comb begin
        w_cond_ok = 1'b0;
        case (cz)
            2'b00:   w_cond_ok = 1'b1;
            2'b10:   w_cond_ok = r_flag_c;
            2'b01:   w_cond_ok = r_flag_z;
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_suppress   = w_alu_group && (cz != 2'b11) && !w_cond_ok;
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR);
    // A late mem_ack in the cycle the counter hits TIMEOUT still wins.
    assign w_timeout    = w_wait_state && !mem_ack && (r_wait == C_TIMEOUT);

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        fault      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                // Branch target is computed here into ALUOut.
                alu_src_b = 2'b11;
                if ((op == C_OP_LW) || (op == C_OP_SW)) begin
                    w_next = S_MEMADR;
                end else if (op == C_OP_BEQ) begin
                    w_next = S_BEQ;
                end else if (w_alu_group && (cz != 2'b11)) begin
                    w_next = w_suppress ? S_FETCH : S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack)        w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ack)        w_next = S_FETCH;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = alu_zero;
                w_next    = S_FETCH;
            end
            S_FAULT: begin
                fault  = 1'b1;
                w_next = S_FAULT;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset must drop every control at once, including the Mealy terms
        // that would otherwise follow mem_ack in FETCH.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal_op = 1'b0;
            fault      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || mem_ack) begin
                r_wait <= '0;
            end else if (w_wait_state) begin
                r_wait <= r_wait + C_ONE;
            end
            if (r_state == S_EXEC) begin
                r_flag_z <= alu_zero;
                // NAND has no carry-out, so C survives it.
                if (op == C_OP_ADD) begin
                    r_flag_c <= alu_carry;
                end
            end
        end
    end

    assign flag_c = r_flag_c;
    assign flag_z = r_flag_z;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_instr_count;
    logic             w_retire;

    // Retirement is the return to FETCH from a completing state. A
    // suppressed conditional counts; an illegal instruction does not.
    always_comb begin
        w_retire = 1'b0;
        if (w_next == S_FETCH) begin
            case (r_state)
                S_MEMWB, S_MEMWR, S_RWB, S_BEQ: w_retire = 1'b1;
                S_DECODE:                       w_retire = w_suppress;
                default:                        w_retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_fsm
// Description : Self-checking bench for mc_ctrl_fsm (TIMEOUT=4). Each
//               scenario queues per-cycle stimulus and the expected
//               {controls, flag_c, flag_z, instr_count}. It then drains the
//               queue one clock at a time, comparing against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [1:0]  cz;
    logic        alu_zero, alu_carry, mem_ack;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        reg_write, reg_dst, mem_to_reg, flag_c, flag_z, illegal_op, fault;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.TIMEOUT(4), .TO_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .cz(cz),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .flag_c(flag_c), .flag_z(flag_z), .illegal_op(illegal_op),
        .fault(fault), .instr_count(instr_count)
    );

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
    //  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, fault}
    logic [15:0] outs;
    logic [49:0] obs;
    assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, fault};
    assign obs  = {outs, flag_c, flag_z, instr_count};

    localparam logic [15:0] V_RST    = 16'h0000;
    localparam logic [15:0] V_FWAIT  = 16'h8080;
    localparam logic [15:0] V_FACK   = 16'h9880;
    localparam logic [15:0] V_DEC    = 16'h0180;
    localparam logic [15:0] V_DECILL = 16'h0182;
    localparam logic [15:0] V_MEMADR = 16'h0300;
    localparam logic [15:0] V_MEMRD  = 16'hA000;
    localparam logic [15:0] V_MEMWB  = 16'h0014;
    localparam logic [15:0] V_MEMWR  = 16'hE000;
    localparam logic [15:0] V_EXEC   = 16'h0240;
    localparam logic [15:0] V_RWB    = 16'h0018;
    localparam logic [15:0] V_BEQT   = 16'h0E20;
    localparam logic [15:0] V_BEQN   = 16'h0620;
    localparam logic [15:0] V_FAULT  = 16'h0001;

    int checks = 0;
    int errors = 0;

    logic [8:0]  stim[$];   // {op, cz, mem_ack, alu_zero, alu_carry}
    logic [49:0] sb[$];
    logic [49:0] exp_v;

    logic        m_c = 1'b0;
    logic        m_z = 1'b0;
    logic [31:0] m_cnt = '0;

    function automatic logic [31:0] cnt_model();
`ifdef MC_CTRL_PERF_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input logic [3:0] o, input logic [1:0] c2, input logic ack,
                        input logic z, input logic c, input logic [15:0] v);
        stim.push_back({o, c2, ack, z, c});
        sb.push_back({v, m_c, m_z, cnt_model()});
    endtask

    task automatic apply_next();
        logic [8:0] s;
        @(negedge clk);
        s = stim.pop_front();
        {op, cz, mem_ack, alu_zero, alu_carry} = s;
        #1;
    endtask

    // ALU-group instruction; taken unless the cz condition fails.
    task automatic q_alu(input logic [3:0] o, input logic [1:0] c2, input int fwait,
                         input bit taken, input logic ac, input logic az);
        for (int i = 0; i < fwait; i++) push(o, c2, 1'b0, 1'b0, 1'b0, V_FWAIT);
        push(o, c2, 1'b1, 1'b0, 1'b0, V_FACK);
        push(o, c2, 1'b0, 1'b0, 1'b0, V_DEC);
        if (taken) begin
            push(o, c2, 1'b0, az, ac, V_EXEC);
            m_z = az;
            if (o == 4'b0000) m_c = ac;
            push(o, c2, 1'b0, 1'b0, 1'b0, V_RWB);
        end
        m_cnt = m_cnt + 1;
    endtask

    task automatic q_mem(input bit lw, input int fwait, input int mwait);
        logic [3:0] o;
        o = lw ? 4'b1010 : 4'b1001;
        for (int i = 0; i < fwait; i++) push(o, 2'b00, 1'b0, 1'b0, 1'b0, V_FWAIT);
        push(o, 2'b00, 1'b1, 1'b0, 1'b0, V_FACK);
        push(o, 2'b00, 1'b0, 1'b0, 1'b0, V_DEC);
        push(o, 2'b00, 1'b0, 1'b0, 1'b0, V_MEMADR);
        for (int i = 0; i < mwait; i++)
            push(o, 2'b00, 1'b0, 1'b0, 1'b0, lw ? V_MEMRD : V_MEMWR);
        push(o, 2'b00, 1'b1, 1'b0, 1'b0, lw ? V_MEMRD : V_MEMWR);
        if (lw) push(o, 2'b00, 1'b0, 1'b0, 1'b0, V_MEMWB);
        m_cnt = m_cnt + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 4'b0000; cz = 2'b00;
        mem_ack = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (obs !== 50'd0) begin
            errors++;
            $display("FAIL reset_idle: got %h, expected %h", obs, 50'd0);
        end
        mem_ack = 1'b1; #1;
        checks++;
        if (obs !== 50'd0) begin
            errors++;
            $display("FAIL reset_ack_gated: got %h, expected %h", obs, 50'd0);
        end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0; #1;
        checks++;
        if (obs !== {V_FWAIT, 2'b00, 32'd0}) begin
            errors++;
            $display("FAIL reset_release: got %h, expected %h", obs, {V_FWAIT, 2'b00, 32'd0});
        end
    endtask

    task automatic test_alu();
        q_alu(4'b0000, 2'b00, 0, 1'b1, 1'b1, 1'b0);   // ADD: C=1 Z=0
        q_alu(4'b0010, 2'b00, 2, 1'b1, 1'b0, 1'b1);   // NAND: Z=1, C kept
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL alu: got %h, expected %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_cond();
        q_alu(4'b0000, 2'b00, 0, 1'b1, 1'b0, 1'b0);   // clear both flags
        q_alu(4'b0000, 2'b10, 0, 1'b0, 1'b1, 1'b1);   // ADC suppressed
        q_alu(4'b0010, 2'b01, 0, 1'b0, 1'b1, 1'b1);   // NDZ suppressed
        q_alu(4'b0000, 2'b00, 0, 1'b1, 1'b1, 1'b1);   // C=1 Z=1
        q_alu(4'b0000, 2'b10, 0, 1'b1, 1'b0, 1'b0);   // ADC taken
        q_alu(4'b0000, 2'b00, 0, 1'b1, 1'b1, 1'b0);   // C=1 Z=0
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL cond: got %h, expected %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_mem();
        q_mem(1'b1, 0, 3);   // LW, 3 wait states in MEMRD
        q_mem(1'b1, 0, 4);   // ack exactly when the counter hits TIMEOUT
        q_mem(1'b0, 2, 0);   // SW with fetch wait states
        q_mem(1'b0, 0, 1);
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mem: got %h, expected %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_beq();
        push(4'b1011, 2'b00, 1'b1, 1'b0, 1'b0, V_FACK);
        push(4'b1011, 2'b00, 1'b0, 1'b0, 1'b0, V_DEC);
        push(4'b1011, 2'b00, 1'b0, 1'b1, 1'b0, V_BEQT);
        m_cnt = m_cnt + 1;
        push(4'b1011, 2'b00, 1'b1, 1'b0, 1'b0, V_FACK);
        push(4'b1011, 2'b00, 1'b0, 1'b0, 1'b0, V_DEC);
        push(4'b1011, 2'b00, 1'b0, 1'b0, 1'b1, V_BEQN);
        m_cnt = m_cnt + 1;
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL beq: got %h, expected %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        push(4'b0111, 2'b00, 1'b1, 1'b0, 1'b0, V_FACK);
        push(4'b0111, 2'b00, 1'b0, 1'b0, 1'b0, V_DECILL);
        push(4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, V_FACK);
        push(4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, V_DECILL);
        push(4'b0010, 2'b11, 1'b1, 1'b0, 1'b0, V_FACK);
        push(4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, V_DECILL);
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL illegal: got %h, expected %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) push(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, V_FWAIT);
        for (int i = 0; i < 3; i++) push(4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, V_FAULT);
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL timeout: got %h, expected %h", obs, exp_v);
            end
        end
        @(negedge clk);
        reset = 1'b1; #1;
        m_c = 1'b0; m_z = 1'b0; m_cnt = '0;
        checks++;
        if (obs !== 50'd0) begin
            errors++;
            $display("FAIL timeout_reset: got %h, expected %h", obs, 50'd0);
        end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0; #1;
        checks++;
        if (obs !== {V_FWAIT, 2'b00, 32'd0}) begin
            errors++;
            $display("FAIL timeout_restart: got %h, expected %h", obs, {V_FWAIT, 2'b00, 32'd0});
        end
    endtask

    task automatic test_reset_mid();
        push(4'b1010, 2'b00, 1'b1, 1'b0, 1'b0, V_FACK);
        push(4'b1010, 2'b00, 1'b0, 1'b0, 1'b0, V_DEC);
        push(4'b1010, 2'b00, 1'b0, 1'b0, 1'b0, V_MEMADR);
        push(4'b1010, 2'b00, 1'b0, 1'b0, 1'b0, V_MEMRD);
        while (sb.size() > 0) begin
            apply_next();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_seq: got %h, expected %h", obs, exp_v);
            end
        end
        @(negedge clk);
        mem_ack = 1'b1; reset = 1'b1; #1;
        checks++;
        if (obs !== 50'd0) begin
            errors++;
            $display("FAIL reset_mid_drop: got %h, expected %h", obs, 50'd0);
        end
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0; #1;
        checks++;
        if (obs !== {V_FWAIT, 2'b00, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_restart: got %h, expected %h", obs, {V_FWAIT, 2'b00, 32'd0});
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_cond();
        test_mem();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
